// File: rtl/eight_digit_capture.sv
// rtl/eight_digit_capture.sv - seven-segment scan bus receiver, reassembles the displayed 32-bit value
module eight_digit_capture #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [7:0]  anodes,
  output logic [31:0] HEX_out,
  output logic        frame_valid,
  output logic        locked,
  output logic [7:0]  digits_seen,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam int RUN_W  = $clog2(STABLE_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  logic [14:0]       pair_q;
  logic [14:0]       pair_prev;
  logic              pair_q_vld;
  logic              pair_prev_vld;
  logic [RUN_W-1:0]  run_len;
  logic [IDLE_W-1:0] idle_cnt;
  logic [31:0]       shadow;

  logic [RUN_W-1:0]  run_next;
  logic              accept;
  logic [6:0]        glyph;
  logic [7:0]        an_low;
  logic              glyph_ok;
  logic [3:0]        nibble;
  logic [2:0]        digit_idx;
  logic              is_blank;
  logic              is_multi;
  logic [7:0]        seen_next;
  logic [31:0]       shadow_next;

  assign glyph    = ~pair_q[6:0];
  assign an_low   = ~pair_q[14:7];
  assign is_blank = (an_low == 8'h00);
  assign is_multi = ($countones(an_low) > 1);

  // Run length of the registered pair; accept fires only on the edge the run first reaches the threshold.
  always_comb begin
    run_next = '0;
    accept   = 1'b0;
    if (pair_q_vld) begin
      if (pair_prev_vld && (pair_q == pair_prev)) begin
        run_next = (run_len == RUN_MAX) ? run_len : run_len + RUN_ONE;
        accept   = (run_len != RUN_MAX) && (run_len + RUN_ONE == RUN_MAX);
      end else begin
        run_next = RUN_ONE;
        accept   = (STABLE_CYCLES == 1);
      end
    end
  end

  always_comb begin
    glyph_ok = 1'b1;
    nibble   = 4'h0;
    case (glyph)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_low[i]) digit_idx = 3'(i);
    end
    seen_next = digits_seen | (8'h01 << digit_idx);
    shadow_next = shadow;
    shadow_next[{digit_idx, 2'b00} +: 4] = nibble;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pair_q        <= '0;
      pair_prev     <= '0;
      pair_q_vld    <= 1'b0;
      pair_prev_vld <= 1'b0;
      run_len       <= '0;
      idle_cnt      <= '0;
      shadow        <= '0;
      HEX_out       <= '0;
      frame_valid   <= 1'b0;
      locked        <= 1'b0;
      digits_seen   <= '0;
      err_pattern   <= 1'b0;
      err_anode     <= 1'b0;
    end else begin
      pair_q        <= {anodes, segments};
      pair_q_vld    <= 1'b1;
      pair_prev     <= pair_q;
      pair_prev_vld <= pair_q_vld;
      run_len       <= run_next;
      frame_valid   <= 1'b0;
      err_pattern   <= 1'b0;
      err_anode     <= 1'b0;
      if (accept && !is_blank) begin
        idle_cnt <= '0;
        if (is_multi) begin
          err_anode <= 1'b1;
        end else if (!glyph_ok) begin
          err_pattern <= 1'b1;
        end else begin
          shadow <= shadow_next;
          if (seen_next == 8'hFF) begin
            HEX_out     <= shadow_next;
            frame_valid <= 1'b1;
            locked      <= 1'b1;
            digits_seen <= 8'h00;
          end else begin
            digits_seen <= seen_next;
          end
        end
      end else if (idle_cnt + IDLE_ONE == IDLE_MAX) begin
        // Stale partial frame; the last completed value stays on HEX_out.
        idle_cnt    <= '0;
        digits_seen <= 8'h00;
      end else begin
        idle_cnt <= idle_cnt + IDLE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_eight_digit_capture.sv
// tb/tb_eight_digit_capture.sv - bench for eight_digit_capture: per-cycle model compare plus directed checks
module tb_eight_digit_capture;

  localparam int S = 2;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segments;
  logic [7:0]  anodes;
  logic [31:0] hex_out;
  logic        frame_valid;
  logic        locked;
  logic [7:0]  digits_seen;
  logic        err_pattern;
  logic        err_anode;

  eight_digit_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock(clk), .reset(reset), .segments(segments), .anodes(anodes),
    .HEX_out(hex_out), .frame_valid(frame_valid), .locked(locked),
    .digits_seen(digits_seen), .err_pattern(err_pattern), .err_anode(err_anode)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_fv = 0, n_ep = 0, n_ea = 0, fv_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sample history, trailing-run rule, per-digit nibble array.
  logic [14:0] hist[$];
  logic [3:0]  m_nib [8];
  logic [7:0]  m_seen;
  logic [31:0] m_hex;
  logic        m_locked, m_fv, m_ep, m_ea;
  int          m_idle;
  bit          model_ready = 0;
  int          run, nlow, idx, val;
  bit          acc, valid;
  logic [14:0] pr;
  logic [7:0]  lows;
  logic [6:0]  gl;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      hist.delete();
      for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
      m_seen = 0; m_hex = 0; m_locked = 0; m_fv = 0; m_ep = 0; m_ea = 0; m_idle = 0;
      model_ready = 1;
    end else begin
      m_fv = 0; m_ep = 0; m_ea = 0;
      acc = 0; nlow = 0; idx = 0; valid = 0; val = 0;
      if (hist.size() >= S) begin
        run = 1;
        for (int k = hist.size() - 2; k >= 0; k--) begin
          if (hist[k] == hist[hist.size()-1]) run++;
          else break;
        end
        acc = (run == S);
        pr = hist[hist.size()-1];
        lows = ~pr[14:7];
        gl = ~pr[6:0];
        for (int k = 0; k < 8; k++) if (lows[k]) begin nlow++; idx = k; end
        for (int v = 0; v < 16; v++) if (glyph_tab[v] == gl) begin valid = 1; val = v; end
      end
      if (acc && nlow > 0) begin
        m_idle = 0;
        if (nlow > 1) m_ea = 1;
        else if (!valid) m_ep = 1;
        else begin
          m_nib[idx] = 4'(val);
          m_seen[idx] = 1'b1;
          if (m_seen == 8'hFF) begin
            for (int k = 0; k < 8; k++) m_hex[4*k +: 4] = m_nib[k];
            m_fv = 1; m_locked = 1; m_seen = 0;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == T) begin m_seen = 0; m_idle = 0; end
      end
      hist.push_back({anodes, segments});
      if (hist.size() > S + 1) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("cyc_hex", hex_out, m_hex);
      chk("cyc_frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("cyc_locked", 32'(locked), 32'(m_locked));
      chk("cyc_digits_seen", 32'(digits_seen), 32'(m_seen));
      chk("cyc_err_pattern", 32'(err_pattern), 32'(m_ep));
      chk("cyc_err_anode", 32'(err_anode), 32'(m_ea));
      if (frame_valid) begin n_fv++; fv_cyc = cyc; end
      if (err_pattern) n_ep++;
      if (err_anode) n_ea++;
    end
  end

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
    anodes = a;
    segments = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int i, input logic [3:0] v, input int n);
    logic [7:0] a;
    a = 8'h01 << i;
    hold(~a, ~glyph_tab[v], n);
  endtask

  task automatic scan(input logic [31:0] value);
    for (int i = 0; i < 8; i++) show(i, value[4*i +: 4], 4);
  endtask

  int fv0, ep0, ea0, c7;

  initial begin
    reset = 1'b1; anodes = 8'hFF; segments = 7'h7F;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_hex", hex_out, 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    chk("reset_seen", 32'(digits_seen), 32'h0);

    // clean scan of 1234ABCD
    fv0 = n_fv;
    for (int i = 0; i < 7; i++) show(i, 4'(32'h1234ABCD >> (4*i)), 4);
    c7 = cyc;
    show(7, 4'h1, 4);
    chk("clean_hex", hex_out, 32'h1234ABCD);
    chk("clean_locked", 32'(locked), 32'h1);
    chk("clean_seen", 32'(digits_seen), 32'h0);
    chk("clean_fv_count", 32'(n_fv - fv0), 32'd1);
    chk("clean_fv_latency", 32'(fv_cyc - c7), 32'd3);

    // one-cycle glitch pair between every digit
    fv0 = n_fv; ep0 = n_ep; ea0 = n_ea;
    for (int i = 0; i < 8; i++) begin
      show(i, 4'(32'h56789EF0 >> (4*i)), 4);
      if (i < 7) hold(8'hFD, ~7'h06, 1);
    end
    hold(8'hFF, 7'h7F, 2);
    chk("glitch_hex", hex_out, 32'h56789EF0);
    chk("glitch_fv_count", 32'(n_fv - fv0), 32'd1);
    chk("glitch_err_count", 32'(n_ep - ep0 + n_ea - ea0), 32'd0);

    // malformed bus states
    ea0 = n_ea; ep0 = n_ep;
    hold(8'hFC, ~7'h06, 3);
    hold(8'hFF, 7'h7F, 2);
    chk("err_anode_count", 32'(n_ea - ea0), 32'd1);
    hold(8'hFE, ~7'h01, 3);
    hold(8'hFF, 7'h7F, 2);
    chk("err_pattern_count", 32'(n_ep - ep0), 32'd1);
    chk("err_pattern_seen0", 32'(digits_seen[0]), 32'h0);

    // reverse order with digit 3 overwritten before the frame ends
    fv0 = n_fv;
    show(7, 4'h1, 4); show(6, 4'h3, 4); show(5, 4'h5, 4); show(4, 4'h7, 4);
    show(3, 4'h9, 4); show(2, 4'h4, 4); show(1, 4'h6, 4); show(3, 4'h2, 4);
    show(0, 4'h8, 4);
    hold(8'hFF, 7'h7F, 2);
    chk("overwrite_hex", hex_out, 32'h13572468);
    chk("overwrite_fv_count", 32'(n_fv - fv0), 32'd1);

    // partial frame discarded by the idle timeout
    fv0 = n_fv;
    for (int i = 0; i < 6; i++) show(i, 4'(i + 10), 4);
    chk("timeout_partial_seen", 32'(digits_seen), 32'h3F);
    hold(8'hFF, 7'h7F, 20);
    chk("timeout_seen", 32'(digits_seen), 32'h0);
    chk("timeout_hex", hex_out, 32'h13572468);
    chk("timeout_locked", 32'(locked), 32'h1);
    chk("timeout_fv_count", 32'(n_fv - fv0), 32'd0);

    // reset in the middle of a frame
    for (int i = 0; i < 4; i++) show(i, 4'(i), 4);
    chk("midreset_pre_seen", 32'(digits_seen), 32'h0F);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset_hex", hex_out, 32'h0);
    chk("midreset_locked", 32'(locked), 32'h0);
    chk("midreset_seen", 32'(digits_seen), 32'h0);
    chk("midreset_pulses", 32'({frame_valid, err_pattern, err_anode}), 32'h0);
    fv0 = n_fv;
    scan(32'h0F1E2D3C);
    hold(8'hFF, 7'h7F, 2);
    chk("rescan_hex", hex_out, 32'h0F1E2D3C);
    chk("rescan_locked", 32'(locked), 32'h1);
    chk("rescan_fv_count", 32'(n_fv - fv0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eight_digit_capture.md
# eight_digit_capture

Receiving end of the eight-digit multiplexed seven-segment bus: watches the scanned `segments`/`anodes` lines, decodes each lit digit back to its hex nibble, and reassembles the 32-bit value being displayed. Used as an in-fabric loopback checker and readback path for the display driver, in the same clock domain. Flags malformed bus states (unknown glyphs, multiple digits enabled at once) and drops partial frames after a scan timeout.

## Interface
- `STABLE_CYCLES`, default 2: consecutive clock edges an (anodes, segments) pair must be held before it is accepted (minimum 1).
- `TIMEOUT_CYCLES`, default 1048576: edges without an accepted digit before the partial frame is discarded.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `segments`  in  7  active-low segment lines; bit0=a … bit6=g.
- `anodes`  in  8  active-low digit enables; `anodes[i]` low selects digit i.
- `HEX_out`  out  32  last complete frame; nibble `HEX_out[4i+3:4i]` comes from digit i.
- `frame_valid`  out  1  one-cycle pulse when `HEX_out` is updated.
- `locked`  out  1  level, high once at least one frame has completed since reset.
- `digits_seen`  out  8  bit i set when digit i has been captured in the current partial frame.
- `err_pattern`  out  1  one-cycle pulse: single anode active, glyph not in the hex set.
- `err_anode`  out  1  one-cycle pulse: two or more anodes active.

## Operation
- Glyph set, shown active-high with bit0=a, to be compared against `~segments`: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other value is invalid.
- Stability filter: compares each registered pair against the previous one. A pair is accepted exactly once per stable run, when the run reaches `STABLE_CYCLES`. A pair is not re-accepted while it stays unchanged. Runs that are shorter than this are ignored.
- Accepted pair classification:
  - All anodes high: blank/idle. No action and no error.
  - Exactly one anode low with a valid glyph: the nibble is written to shadow slot i and `digits_seen[i]` is set. If the slot is already set, the new value overwrites it and the bit stays set.
  - Exactly one anode low with an invalid glyph: `err_pattern` pulses. Shadow and `digits_seen` are unchanged.
  - Two or more anodes low: `err_anode` pulses, regardless of the glyph. Shadow is unchanged.
- Frame completion: the accepted digit sets the last missing bit, so `digits_seen` would become FF. On that edge:
  - `HEX_out` loads the shadow, including the just-captured nibble.
  - `frame_valid` pulses.
  - `locked` sets.
  - `digits_seen` clears to 00.
- Scan order is irrelevant. Any order that covers all eight digits completes a frame.
- Timeout: an idle counter resets on every accepted non-blank pair. When it reaches `TIMEOUT_CYCLES`, `digits_seen` clears and the counter restarts. `HEX_out` and `locked` are retained. No pulse is generated.

## Timing
- Reset values: `HEX_out`=0, `frame_valid`=0, `locked`=0, `digits_seen`=00, `err_pattern`=0, `err_anode`=0. The stability filter and idle counter are cleared. The first pair after reset needs a full `STABLE_CYCLES` run.
- Latency: a pair first present at edge e0 and held through edge e0+`STABLE_CYCLES`-1 produces its effects at edge e0+`STABLE_CYCLES`. The resulting pulses are high for the following cycle only.
- A frame completion and a timeout expiring on the same edge: completion wins. `frame_valid` pulses, and the counter restarts because the accepted digit resets it.
- At most one of `frame_valid`, `err_pattern`, `err_anode` pulses per cycle.
- Reset asserted mid-frame: the partial frame is lost and all outputs return to their reset values on that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Clean scan: with `STABLE_CYCLES`=2, present 0x1234ABCD, holding each digit for 4 cycles in order 0..7 → a single `frame_valid` pulse 2 cycles after digit 7 appears; `HEX_out`=1234ABCD, `locked`=1, `digits_seen`=00.
- Glitch rejection: insert a 1-cycle wrong pair (anodes=FD, segments=~06) between digits → not accepted; `HEX_out` unchanged after the frame; no error pulses.
- Errors: anodes=FC held 3 cycles → one `err_anode` pulse. anodes=FE with segments=~7'h01 → one `err_pattern` pulse, `digits_seen[0]` stays 0.
- Overwrite and out-of-order: scan digits 7..0, then re-send digit 3 with a new value before frame end → `HEX_out` nibble 3 holds the latest value.
- Timeout: with `TIMEOUT_CYCLES`=16, send digits 0-5, then hold blank (anodes=FF) for 20 cycles → `digits_seen` returns to 00; `HEX_out` keeps its previous frame; no `frame_valid`.
- Reset mid-frame: after 4 digits, pulse `reset` for 1 cycle → all outputs are 0, then a fresh full scan completes normally.
